// File: rtl/mem_access_unit.sv
// MEMORY-stage data-memory access unit.
// Turns the EX/MEM register outputs into a single req/ack bus transaction.
// Stores get byte strobes and lane-replicated data. Loads are aligned and
// extended. Misaligned accesses and illegal funct3 values raise a one-cycle
// fault instead of issuing a request. The pipeline is stalled until the
// access has finished.
module mem_access_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_LSB   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_valid_M,
  input  logic                  i_mem_read_M,
  input  logic                  i_mem_write_M,
  input  logic [DATA_WIDTH-1:0] i_alu_result_M,
  input  logic [DATA_WIDTH-1:0] i_write_data_M,
  input  logic [2:0]            i_funct3_M,
  output logic                  o_mem_req,
  output logic                  o_mem_we,
  output logic [DATA_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  output logic [3:0]            o_mem_wstrb,
  input  logic                  i_mem_ack,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata,
  output logic [DATA_WIDTH-1:0] o_read_data_M,
  output logic                  o_stall_M,
  output logic                  o_fault_M
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic                  w_start;
  logic                  w_legal_f3;
  logic                  w_misaligned;
  logic                  w_ok;
  logic [3:0]            w_wstrb;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [DATA_WIDTH-1:0] w_ext;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic [2:0]            r_funct3;
  logic [1:0]            r_off;

  // Decode the incoming access: start condition, legality, alignment.
  // When both read and write are set the write takes priority.
  always_comb begin
    w_start      = (r_state == S_IDLE) && i_valid_M && (i_mem_read_M || i_mem_write_M);
    w_legal_f3   = 1'b0;
    w_misaligned = 1'b0;
    if (i_mem_write_M) begin
      w_legal_f3 = i_funct3_M inside {3'b000, 3'b001, 3'b010};
    end else begin
      w_legal_f3 = i_funct3_M inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    end
    case (i_funct3_M[1:0])
      2'b01:   w_misaligned = i_alu_result_M[0];
      2'b10:   w_misaligned = |i_alu_result_M[1:0];
      default: w_misaligned = 1'b0;
    endcase
    w_ok = w_legal_f3 && !w_misaligned;
  end

  // Store lane placement: replicate data across lanes, strobe selected lanes.
  always_comb begin
    w_wdata = i_write_data_M;
    w_wstrb = 4'b1111;
    case (i_funct3_M[1:0])
      2'b00: begin
        w_wdata = {4{i_write_data_M[7:0]}};
        w_wstrb = 4'b0001 << i_alu_result_M[1:0];
      end
      2'b01: begin
        w_wdata = {2{i_write_data_M[15:0]}};
        w_wstrb = 4'b0011 << {i_alu_result_M[1], 1'b0};
      end
      default: begin
        w_wdata = i_write_data_M;
        w_wstrb = 4'b1111;
      end
    endcase
  end

  // Load alignment and sign/zero extension using the registered offset.
  always_comb begin
    case (r_off)
      2'd0:    w_byte = i_mem_rdata[7:0];
      2'd1:    w_byte = i_mem_rdata[15:8];
      2'd2:    w_byte = i_mem_rdata[23:16];
      default: w_byte = i_mem_rdata[31:24];
    endcase
    w_half = r_off[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
    case (r_funct3)
      3'b000:  w_ext = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_ext = {{16{w_half[15]}}, w_half};
      3'b100:  w_ext = {24'b0, w_byte};
      3'b101:  w_ext = {16'b0, w_half};
      default: w_ext = i_mem_rdata;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and stall. DONE is the single stall-free cycle for the instruction.
  always_comb begin
    w_next    = r_state;
    o_stall_M = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          o_stall_M = 1'b1;
          w_next    = w_ok ? S_REQ : S_DONE;
        end
      end
      S_REQ: begin
        o_stall_M = 1'b1;
        if (i_mem_ack) begin
          w_next = S_DONE;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Bus outputs, fault pulse and load result. Bus fields are held through REQ.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_mem_req     <= 1'b0;
      o_mem_we      <= 1'b0;
      o_mem_addr    <= '0;
      o_mem_wdata   <= '0;
      o_mem_wstrb   <= '0;
      o_read_data_M <= '0;
      o_fault_M     <= 1'b0;
      r_funct3      <= '0;
      r_off         <= '0;
    end else begin
      o_fault_M <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            if (w_ok) begin
              o_mem_req   <= 1'b1;
              o_mem_we    <= i_mem_write_M;
              o_mem_addr  <= {i_alu_result_M[DATA_WIDTH-1:ADDR_LSB], {ADDR_LSB{1'b0}}};
              o_mem_wdata <= i_mem_write_M ? w_wdata : '0;
              o_mem_wstrb <= i_mem_write_M ? w_wstrb : '0;
              r_funct3    <= i_funct3_M;
              r_off       <= i_alu_result_M[1:0];
            end else begin
              o_fault_M <= 1'b1;
            end
          end
        end
        S_REQ: begin
          if (i_mem_ack) begin
            o_mem_req <= 1'b0;
            if (!o_mem_we) begin
              o_read_data_M <= w_ext;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: directed plan cases plus randomized accesses,
// checked against a lane/size-based reference model.
module tb_mem_access_unit;

  logic        clk;
  logic        rst;
  logic        valid_i;
  logic        rd_i;
  logic        wr_i;
  logic [31:0] addr_i;
  logic [31:0] wd_i;
  logic [2:0]  f3_i;
  logic        o_mem_req;
  logic        o_mem_we;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [3:0]  o_mem_wstrb;
  logic        ack_i;
  logic [31:0] rdata_i;
  logic [31:0] o_read_data_M;
  logic        o_stall_M;
  logic        o_fault_M;

  int          checks;
  int          errors;
  logic [31:0] m_hold;

  mem_access_unit #(.DATA_WIDTH(32), .ADDR_LSB(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_valid_M      (valid_i),
    .i_mem_read_M   (rd_i),
    .i_mem_write_M  (wr_i),
    .i_alu_result_M (addr_i),
    .i_write_data_M (wd_i),
    .i_funct3_M     (f3_i),
    .o_mem_req      (o_mem_req),
    .o_mem_we       (o_mem_we),
    .o_mem_addr     (o_mem_addr),
    .o_mem_wdata    (o_mem_wdata),
    .o_mem_wstrb    (o_mem_wstrb),
    .i_mem_ack      (ack_i),
    .i_mem_rdata    (rdata_i),
    .o_read_data_M  (o_read_data_M),
    .o_stall_M      (o_stall_M),
    .o_fault_M      (o_fault_M)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: access size in bytes, or 0 when the funct3 is not allowed.
  function automatic int m_size(input bit is_w, input logic [2:0] f3);
    int sz;
    sz = 0;
    if (is_w) begin
      if (f3 == 3'd0) sz = 1;
      else if (f3 == 3'd1) sz = 2;
      else if (f3 == 3'd2) sz = 4;
    end else begin
      if (f3 == 3'd0 || f3 == 3'd4) sz = 1;
      else if (f3 == 3'd1 || f3 == 3'd5) sz = 2;
      else if (f3 == 3'd2) sz = 4;
    end
    return sz;
  endfunction

  function automatic logic [3:0] m_wstrb(input int off, input int sz);
    logic [3:0] s;
    s = '0;
    for (int i = 0; i < 4; i++) begin
      if (i >= off && i < off + sz) s[i] = 1'b1;
    end
    return s;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [31:0] wd, input int sz);
    if (sz == 1) return (wd & 32'hFF) * 32'h0101_0101;
    if (sz == 2) return (wd & 32'hFFFF) * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] rdata, input logic [2:0] f3,
                                         input int off, input int sz);
    longint v;
    longint span;
    if (sz == 4) return rdata;
    span = longint'(1) << (8 * sz);
    v = (longint'(rdata) >> (8 * off)) % span;
    if (!f3[2] && v >= span / 2) v = v - span;
    return 32'(v);
  endfunction

  // One complete access. delay = number of REQ cycles without ack before the ack cycle.
  task automatic access(input bit rd, input bit wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input int delay, input logic [31:0] rdata);
    int sz;
    int off;
    int stall_n;
    bit is_w;
    logic [31:0] exp_addr;
    @(negedge clk);
    valid_i = 1'b1; rd_i = rd; wr_i = wr; f3_i = f3; addr_i = addr; wd_i = wd;
    #1;
    if (!(rd || wr)) begin
      chk("noacc_stall", 32'(o_stall_M), 32'd0);
      @(posedge clk); #1;
      chk("noacc_req", 32'(o_mem_req), 32'd0);
      chk("noacc_fault", 32'(o_fault_M), 32'd0);
      valid_i = 1'b0;
      return;
    end
    is_w     = wr;
    sz       = m_size(is_w, f3);
    off      = int'(addr % 4);
    exp_addr = addr - (addr % 4);
    chk("start_stall", 32'(o_stall_M), 32'd1);
    stall_n = int'(o_stall_M);
    @(posedge clk); #1;
    valid_i = 1'b0; rd_i = 1'b0; wr_i = 1'b0;
    if (sz == 0 || (addr % sz) != 0) begin
      chk("fault_pulse", 32'(o_fault_M), 32'd1);
      chk("fault_noreq", 32'(o_mem_req), 32'd0);
      chk("fault_done_stall", 32'(o_stall_M), 32'd0);
      chk("fault_rd_hold", o_read_data_M, m_hold);
      @(posedge clk); #1;
      chk("fault_clear", 32'(o_fault_M), 32'd0);
      chk("fault_noreq2", 32'(o_mem_req), 32'd0);
      return;
    end
    chk("req", 32'(o_mem_req), 32'd1);
    chk("we", 32'(o_mem_we), 32'(is_w));
    chk("addr", o_mem_addr, exp_addr);
    chk("wstrb", 32'(o_mem_wstrb), is_w ? 32'(m_wstrb(off, sz)) : 32'd0);
    if (is_w) chk("wdata", o_mem_wdata, m_wdata(wd, sz));
    for (int k = 0; k < delay; k++) begin
      stall_n += int'(o_stall_M);
      @(posedge clk); #1;
      chk("req_hold", 32'(o_mem_req), 32'd1);
      chk("addr_hold", o_mem_addr, exp_addr);
    end
    stall_n += int'(o_stall_M);
    @(negedge clk);
    ack_i = 1'b1; rdata_i = rdata;
    @(posedge clk); #1;
    ack_i = 1'b0; rdata_i = $urandom;
    chk("done_req", 32'(o_mem_req), 32'd0);
    chk("done_stall", 32'(o_stall_M), 32'd0);
    chk("stall_cycles", 32'(stall_n), 32'(delay + 2));
    if (!is_w) m_hold = m_load(rdata, f3, off, sz);
    chk("read_data", o_read_data_M, m_hold);
    @(posedge clk); #1;
    chk("idle_stall", 32'(o_stall_M), 32'd0);
    chk("idle_req", 32'(o_mem_req), 32'd0);
  endtask

  initial begin
    checks = 0; errors = 0; m_hold = '0;
    rst = 1'b0; valid_i = 1'b0; rd_i = 1'b0; wr_i = 1'b0;
    addr_i = '0; wd_i = '0; f3_i = '0; ack_i = 1'b0; rdata_i = '0;
    #1;
    chk("rst_req", 32'(o_mem_req), 32'd0);
    chk("rst_we", 32'(o_mem_we), 32'd0);
    chk("rst_fault", 32'(o_fault_M), 32'd0);
    chk("rst_stall", 32'(o_stall_M), 32'd0);
    chk("rst_addr", o_mem_addr, 32'd0);
    chk("rst_wdata", o_mem_wdata, 32'd0);
    chk("rst_wstrb", 32'(o_mem_wstrb), 32'd0);
    chk("rst_rdata", o_read_data_M, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Directed plan cases.
    access(1, 0, 3'b010, 32'h0000_1008, 32'h0, 1, 32'hDEAD_BEEF);
    chk("plan_lw", o_read_data_M, 32'hDEAD_BEEF);
    access(1, 0, 3'b000, 32'h0000_1003, 32'h0, 0, 32'h80FF_1234);
    chk("plan_lb", o_read_data_M, 32'hFFFF_FF80);
    access(1, 0, 3'b100, 32'h0000_1003, 32'h0, 0, 32'h80FF_1234);
    chk("plan_lbu", o_read_data_M, 32'h0000_0080);
    access(1, 0, 3'b101, 32'h0000_1002, 32'h0, 0, 32'h80FF_1234);
    chk("plan_lhu", o_read_data_M, 32'h0000_80FF);
    access(0, 1, 3'b000, 32'h0000_2001, 32'h0000_00A5, 0, 32'h0);
    chk("plan_sb_wdata", o_mem_wdata, 32'hA5A5_A5A5);
    chk("plan_sb_wstrb", 32'(o_mem_wstrb), 32'h2);
    access(0, 1, 3'b001, 32'h0000_2002, 32'h0000_1234, 2, 32'h0);
    chk("plan_sh_wdata", o_mem_wdata, 32'h1234_1234);
    chk("plan_sh_wstrb", 32'(o_mem_wstrb), 32'hC);
    chk("plan_store_rd_hold", o_read_data_M, 32'h0000_80FF);
    access(1, 0, 3'b010, 32'h0000_3002, 32'h0, 0, 32'h0);
    access(0, 1, 3'b001, 32'h0000_3001, 32'h0, 0, 32'h0);
    access(1, 0, 3'b011, 32'h0000_3000, 32'h0, 0, 32'h0);
    access(1, 1, 3'b010, 32'h0000_4000, 32'hCAFE_F00D, 0, 32'h1111_1111);
    access(1, 1, 3'b100, 32'h0000_4000, 32'hCAFE_F00D, 0, 32'h0);

    // Spurious ack in IDLE, then a long ack wait.
    @(negedge clk);
    ack_i = 1'b1; rdata_i = 32'h5555_AAAA;
    @(posedge clk); #1;
    ack_i = 1'b0;
    chk("spur_req", 32'(o_mem_req), 32'd0);
    chk("spur_stall", 32'(o_stall_M), 32'd0);
    chk("spur_fault", 32'(o_fault_M), 32'd0);
    chk("spur_rd_hold", o_read_data_M, m_hold);
    access(1, 0, 3'b001, 32'h0000_5006, 32'h0, 10, 32'h8001_7FFF);

    // Asynchronous reset in the middle of REQ.
    @(negedge clk);
    valid_i = 1'b1; rd_i = 1'b1; wr_i = 1'b0; f3_i = 3'b010; addr_i = 32'h0000_6000;
    @(posedge clk); #1;
    valid_i = 1'b0; rd_i = 1'b0;
    chk("arst_req_before", 32'(o_mem_req), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("arst_req", 32'(o_mem_req), 32'd0);
    chk("arst_stall", 32'(o_stall_M), 32'd0);
    m_hold = '0;
    chk("arst_rdata", o_read_data_M, m_hold);
    @(negedge clk);
    rst = 1'b1;
    access(1, 0, 3'b000, 32'h0000_7001, 32'h0, 0, 32'h0000_F200);
    access(0, 1, 3'b010, 32'h0000_7004, 32'h1357_9BDF, 1, 32'h0);

    // Randomized accesses.
    for (int n = 0; n < 40; n++) begin
      bit          r_rd;
      bit          r_wr;
      logic [2:0]  r_f3;
      logic [31:0] r_addr;
      r_rd   = 1'($urandom_range(0, 1));
      r_wr   = 1'($urandom_range(0, 1));
      r_f3   = 3'($urandom_range(0, 7));
      r_addr = $urandom;
      if ($urandom_range(0, 1) == 1) r_addr = r_addr & ~(32'($urandom_range(0, 3)));
      access(r_rd, r_wr, r_f3, r_addr, $urandom, $urandom_range(0, 3), $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
